rv16_addsub_unit: RTL
=====================

# rv16_addsub_unit

Parametrised, chunk-serial add/subtract unit for the rv16 datapath. It replaces the fixed 16-bit ripple subtractor with a single carry/borrow engine that processes `CHUNK` bits per clock. It provides a valid/ready handshake on both sides, carry-in/borrow-in and carry-out/borrow-out, and Z/N/V flags. It sits between the register-read stage and the ALU result mux, and trades latency for a short carry path.

## Interface
- `DATA`, 16, operand/result width; must be a multiple of `CHUNK`.
- `CHUNK`, 4, bits processed per cycle; `N = DATA/CHUNK` is the number of compute cycles.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept; high only in IDLE and while `rst_n` is high.
- `op_sub`  in  1  0 = add, 1 = subtract.
- `rs1_in`  in  DATA  first operand.
- `rs2_in`  in  DATA  second operand.
- `cin`  in  1  carry-in for add; borrow-in for subtract.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts the result.
- `rd_out`  out  DATA  result.
- `cout`  out  1  carry-out for add; borrow-out for subtract.
- `flag_z`, `flag_n`, `flag_v`  out  1 each  zero, negative, signed overflow.
- `sat`  in  1  saturate on signed overflow; present only with `RV16_ADDSUB_SAT_EN`.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE → BUSY:** on the edge where `in_valid & in_ready`.
  - Captures `rs1_in`, `rs2_in`, `op_sub`, `cin` (and `sat`).
  - Clears the chunk counter.
  - Loads the carry register with `cin` for add, `~cin` for subtract.
- **Internal arithmetic:** `rs1 + (op_sub ? ~rs2 : rs2) + carry`, computed modulo 2^DATA.
- **BUSY:** each edge processes chunk `k`, bits `[k*CHUNK +: CHUNK]`, LSB chunk first.
  - Writes that chunk of the result register.
  - Updates the carry register.
  - Increments `k`.
  - On the edge processing chunk `N-1`, also records carry into the MSB and carry out of the MSB, then moves to DONE.
- **Flags and carry-out:**
  - `cout` = final carry for add; `~final carry` for subtract. Subtract borrow is 1 iff `rs1 < rs2 + bin`, unsigned.
  - `flag_v` = carry-into-MSB XOR carry-out-of-MSB, always taken from the raw (unsaturated) result.
  - `flag_z` = (`rd_out == 0`); `flag_n` = `rd_out[DATA-1]`. Both reflect the final `rd_out`, after any saturation.
- **DONE:** `out_valid = 1`; `rd_out`, `cout` and flags are held stable until `out_valid & out_ready`, then the FSM returns to IDLE.
  - `in_ready = 0` in DONE; there is no overlap.
- **Isolation:** input changes while in BUSY or DONE are ignored. `in_valid` in a state other than IDLE is not accepted and is not lost; the producer holds it.
- **Reset values:** while `rst_n` is low at an edge, including mid-BUSY or in DONE, the next state is IDLE and every output is 0: `out_valid`, `rd_out`, `cout`, all flags, and the counter. Any in-flight operation is discarded.

## Timing
- Accept edge = E0. BUSY edges = E1..EN. `out_valid` is high from after EN.
- Latency is N cycles (4 at defaults).
- Pop edge Ep: DONE → IDLE. The earliest next accept is Ep+1. Sustained throughput is one op per N+2 cycles.
- Outputs are registered; there are no combinational paths from inputs to `out_valid` or `rd_out`.
- `in_ready` is decoded from state, gated by `rst_n`.
- The critical path is one CHUNK-bit adder plus the carry register.

## Configuration
- `RV16_ADDSUB_SAT_EN` defined:
  - Adds the `sat` port, which is captured at accept.
  - If `sat = 1` and overflow occurs, `rd_out` clamps to `{0,1...1}` for positive overflow or `{1,0...0}` for negative overflow. The sign is taken from `rs1` MSB.
  - `flag_v` still reports the overflow.
- Macro undefined: no `sat` port; results always wrap.

## Structure
- Package `rv16_pkg`:
  - `RV16_DATA = 16`.
  - Enum `addsub_state_t {IDLE, BUSY, DONE}`.
  - Op encoding constants `OP_ADD = 1'b0`, `OP_SUB = 1'b1`.
- Sub-module `rv16_chunk_adder`: combinational `CHUNK`-bit adder with inputs `a`, `b`, `ci` and outputs `s`, `co`, and `c_msb` (carry into its top bit). It is instantiated once.

## Test plan
- Add `0x1234 + 0x0001`, `cin = 0` → `rd = 0x1235`, `cout = 0`, Z/N/V = 0/0/0, `out_valid` exactly 4 edges after accept.
- Sub `0x0000 - 0x0001`, `bin = 0` → `rd = 0xFFFF`, `cout = 1`, N = 1, V = 0. Sub `0x0005 - 0x0005`, `bin = 0` → `rd = 0x0000`, Z = 1, `cout = 0`. The same operands with `bin = 1` → `rd = 0xFFFF`, `cout = 1`.
- Add `0x7FFF + 0x0001` → `rd = 0x8000`, V = 1, N = 1. With `SAT_EN` and `sat = 1` → `rd = 0x7FFF`, V = 1, N = 0.
- Sub `0x8000 - 0x0001` → `rd = 0x7FFF`, V = 1, `cout = 0`. With `sat = 1` → `rd = 0x8000`, N = 1.
- Backpressure: hold `out_ready = 0` for 5 cycles with `in_valid = 1` and new operands.
  - Required: `rd_out` and flags stay stable, and `in_ready = 0` throughout.
  - Pop, then the new op is accepted on the next edge and produces the correct result.
- Reset mid-op: drive `rst_n = 0` for one edge at the 2nd BUSY cycle.
  - Required: after that edge, all outputs are 0 and state is IDLE.
  - The following add `0xFFFF + 0x0001` → `rd = 0x0000`, `cout = 1`, Z = 1.

Source files
------------

// File: rtl/rv16_pkg.sv
// Purpose: shared types and constants for the rv16 add/subtract datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default data width, FSM state encoding, op encoding.
package rv16_pkg;

    localparam int RV16_DATA = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/rv16_chunk_adder.sv
// Purpose: combinational W-bit adder slice used by the chunk-serial add/sub engine.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
// Ports: a, b (W-bit operands), ci (carry in) -> s (sum), co (carry out of top bit),
//        c_msb (carry into top bit, used for signed-overflow detection).
module rv16_chunk_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [W:0] sum;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        s     = sum[W-1:0];
        co    = sum[W];
        // Top sum bit = a ^ b ^ carry_in, so the carry into it falls out by XOR.
        c_msb = a[W-1] ^ b[W-1] ^ sum[W-1];
    end

endmodule

// File: rtl/rv16_addsub_unit.sv
// Purpose: chunk-serial add/subtract unit (CHUNK bits per cycle) with carry/borrow and Z/N/V flags.
// Latency: DATA/CHUNK cycles from accept edge to out_valid; one op per DATA/CHUNK+2 cycles sustained.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no overlap.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready, op_sub, rs1_in, rs2_in, cin [, sat];
//        out_valid/out_ready, rd_out, cout, flag_z, flag_n, flag_v.
// Config macro: RV16_ADDSUB_SAT_EN adds the sat input (clamp on signed overflow).
module rv16_addsub_unit
    import rv16_pkg::*;
#(
    parameter int DATA  = RV16_DATA,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op_sub,
    input  logic [DATA-1:0] rs1_in,
    input  logic [DATA-1:0] rs2_in,
    input  logic            cin,
`ifdef RV16_ADDSUB_SAT_EN
    input  logic            sat,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DATA-1:0] rd_out,
    output logic            cout,
    output logic            flag_z,
    output logic            flag_n,
    output logic            flag_v
);

    localparam int N     = DATA / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    addsub_state_t   state_q, state_d;
    logic [DATA-1:0] a_q, a_d;
    logic [DATA-1:0] b_q, b_d;
    logic            sub_q, sub_d;
    logic            carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA-1:0] res_q, res_d;
    logic            cout_q, cout_d;
    logic            z_q, z_d;
    logic            n_q, n_d;
    logic            v_q, v_d;

`ifdef RV16_ADDSUB_SAT_EN
    logic            sat_q, sat_d;
`else
    logic            sat_q;
    assign sat_q = 1'b0;
`endif

    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             co_chunk, cmsb_chunk;
    logic [DATA-1:0]  raw_full;
    logic [DATA-1:0]  res_fin;
    logic             ovf;

    assign a_chunk = a_q[cnt_q*CHUNK +: CHUNK];
    assign b_chunk = b_q[cnt_q*CHUNK +: CHUNK];

    rv16_chunk_adder #(.W(CHUNK)) u_chunk_adder (
        .a     (a_chunk),
        .b     (b_chunk),
        .ci    (carry_q),
        .s     (s_chunk),
        .co    (co_chunk),
        .c_msb (cmsb_chunk)
    );

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign rd_out    = res_q;
    assign cout      = cout_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_v    = v_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cout_d  = cout_q;
        z_d     = z_q;
        n_d     = n_q;
        v_d     = v_q;
`ifdef RV16_ADDSUB_SAT_EN
        sat_d   = sat_q;
`endif

        // Result with the current chunk merged in; only meaningful in BUSY.
        raw_full = res_q;
        raw_full[cnt_q*CHUNK +: CHUNK] = s_chunk;
        ovf = cmsb_chunk ^ co_chunk;

        // Clamp direction follows rs1's sign: overflow can only push the result
        // past the end of the range rs1 already sits in.
        res_fin = raw_full;
        if (sat_q && ovf) begin
            res_fin = a_q[DATA-1] ? {1'b1, {(DATA-1){1'b0}}} : {1'b0, {(DATA-1){1'b1}}};
        end

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = rs1_in;
                    // rs2 is stored pre-inverted for subtract so BUSY sees only an add.
                    b_d     = (op_sub == OP_SUB) ? ~rs2_in : rs2_in;
                    sub_d   = op_sub;
                    // Subtract is rs1 + ~rs2 + 1 - bin, hence the inverted borrow-in.
                    carry_d = (op_sub == OP_SUB) ? ~cin : cin;
                    cnt_d   = '0;
`ifdef RV16_ADDSUB_SAT_EN
                    sat_d   = sat;
`endif
                    state_d = BUSY;
                end
            end
            BUSY: begin
                res_d   = raw_full;
                carry_d = co_chunk;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    res_d   = res_fin;
                    v_d     = ovf;
                    cout_d  = sub_q ? ~co_chunk : co_chunk;
                    z_d     = (res_fin == '0);
                    n_d     = res_fin[DATA-1];
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
`ifdef RV16_ADDSUB_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
`ifdef RV16_ADDSUB_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

endmodule
